// File: rtl/instr_sequencer.sv
// Program-buffer instruction sequencer: stores up to DEPTH instruction words and,
// on start, issues them one per clock to the ALU stage, driving an idle no-op otherwise.
module instr_sequencer #(
    parameter int              DEPTH      = 16,
    parameter int              AW         = 4,
    parameter int              IW         = 16,
    parameter logic [IW-1:0]   IDLE_INSTR = 16'h4000
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load_en,
    input  logic [AW-1:0]  load_addr,
    input  logic [IW-1:0]  load_data,
    input  logic [AW:0]    prog_len,
    input  logic           start,
    input  logic           abort,
    output logic [IW-1:0]  instruction,
    output logic           issue_valid,
    output logic [AW-1:0]  pc,
    output logic           busy,
    output logic           done
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [IW-1:0]  r_buf [DEPTH];
    logic [IW-1:0]  r_instr;
    logic           r_valid;
    logic [AW-1:0]  r_pc;
    logic [AW-1:0]  r_remaining;
    logic           r_done;

    logic [AW:0]    w_len;
    logic           w_start_ok;
    logic [AW-1:0]  w_pc_inc;
    logic [IW-1:0]  w_instr_nxt;
    logic           w_valid_nxt;
    logic [AW-1:0]  w_pc_nxt;
    logic [AW-1:0]  w_remaining_nxt;
    logic           w_done_nxt;

    assign w_len      = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
    assign w_start_ok = (r_state == S_IDLE) && start && !load_en && (prog_len != '0);
    assign w_pc_inc   = r_pc + 1'b1;

    // NOTE: the buffer is cleared by reset so an unloaded slot always issues the idle no-op;
    // this makes it a register file rather than an inferable RAM block.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_buf[i] <= IDLE_INSTR;
        end else if (load_en && (r_state == S_IDLE)) begin
            r_buf[load_addr] <= load_data;
        end
    end

    // NOTE: all state here updates with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_instr     <= IDLE_INSTR;
            r_valid     <= 1'b0;
            r_pc        <= '0;
            r_remaining <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_instr     <= w_instr_nxt;
            r_valid     <= w_valid_nxt;
            r_pc        <= w_pc_nxt;
            r_remaining <= w_remaining_nxt;
            r_done      <= w_done_nxt;
        end
    end

    // NOTE: every comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_start_ok) w_state_nxt = S_RUN;
            S_RUN:  if (abort || (r_remaining == '0)) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_instr_nxt     = IDLE_INSTR;
        w_valid_nxt     = 1'b0;
        w_pc_nxt        = '0;
        w_remaining_nxt = '0;
        w_done_nxt      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_instr_nxt     = r_buf[0];
                    w_valid_nxt     = 1'b1;
                    w_remaining_nxt = AW'(w_len - 1'b1);
                end
            end
            S_RUN: begin
                // abort wins over a run-end on the same edge and never raises done
                if (!abort) begin
                    if (r_remaining == '0) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_instr_nxt     = r_buf[w_pc_inc];
                        w_valid_nxt     = 1'b1;
                        w_pc_nxt        = w_pc_inc;
                        w_remaining_nxt = r_remaining - 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign instruction = r_instr;
    assign issue_valid = r_valid;
    assign pc          = r_pc;
    assign busy        = (r_state == S_RUN);
    assign done        = r_done;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed scenarios plus randomized runs,
// checked against a queue/array model of the program buffer and a small downstream ALU.
module tb_instr_sequencer;

    localparam logic [15:0] IDLE_W = 16'h4000;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_en;
    logic [3:0]  load_addr;
    logic [15:0] load_data;
    logic [4:0]  prog_len;
    logic        start;
    logic        abort;
    logic [15:0] instruction;
    logic        issue_valid;
    logic [3:0]  pc;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] model_buf [16];
    logic [7:0]  dmem      [16];

    typedef struct packed {
        logic [15:0] instr;
        logic        valid;
        logic [3:0]  pc;
        logic        busy;
        logic        done;
    } obs_t;

    instr_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .prog_len    (prog_len),
        .start       (start),
        .abort       (abort),
        .instruction (instruction),
        .issue_valid (issue_valid),
        .pc          (pc),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Downstream ALU: op 0 loads immediate src2, op 4 ORs, op B adds; executes the word on the bus.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) dmem[i] <= 8'h00;
        end else if (!$isunknown(instruction)) begin
            case (instruction[15:12])
                4'h0: dmem[instruction[3:0]] <= {4'h0, instruction[7:4]};
                4'h4: dmem[instruction[3:0]] <= dmem[instruction[11:8]] | dmem[instruction[7:4]];
                4'hB: dmem[instruction[3:0]] <= dmem[instruction[11:8]] + dmem[instruction[7:4]];
                default: ;
            endcase
        end
    end

    function automatic obs_t obs();
        return '{instruction, issue_valid, pc, busy, done};
    endfunction

    function automatic obs_t idle_exp(input logic d);
        return '{instr: IDLE_W, valid: 1'b0, pc: 4'd0, busy: 1'b0, done: d};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [3:0] a, input logic [15:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        step();
        load_en = 1'b0;
        model_buf[a] = d;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) model_buf[i] = IDLE_W;
    endtask

    // Runs one program; abort_at = index of the visible word whose ending edge sees abort (-1: none).
    // Returns with done visible (normal end) or idle visible (abort / ignored start).
    task automatic run_check(input string name, input logic [4:0] len, input int abort_at, input bit noisy);
        int   l;
        obs_t e;
        l = (len > 5'd16) ? 16 : int'(len);
        prog_len = len; start = 1'b1; load_en = 1'b0; abort = 1'b0;
        step();
        if (l == 0) begin
            start = 1'b0;
            n_checks++;
            if (obs() !== idle_exp(1'b0)) begin
                n_fail++;
                $display("FAIL %s zero-length: got %h expected %h", name, obs(), idle_exp(1'b0));
            end
            return;
        end
        for (int i = 0; i < l; i++) begin
            e = '{instr: model_buf[i], valid: 1'b1, pc: i[3:0], busy: 1'b1, done: 1'b0};
            n_checks++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL %s word %0d: got %h expected %h", name, i, obs(), e);
            end
            if (noisy) begin
                start = 1'($urandom_range(0, 1)); load_en = 1'($urandom_range(0, 1));
                load_addr = 4'($urandom); load_data = 16'($urandom);
            end else begin
                start = 1'b0;
            end
            abort = (i == abort_at);
            step();
            abort = 1'b0;
            if (i == abort_at) begin
                start = 1'b0; load_en = 1'b0;
                n_checks++;
                if (obs() !== idle_exp(1'b0)) begin
                    n_fail++;
                    $display("FAIL %s abort: got %h expected %h", name, obs(), idle_exp(1'b0));
                end
                return;
            end
        end
        start = 1'b0; load_en = 1'b0;
        n_checks++;
        if (obs() !== idle_exp(1'b1)) begin
            n_fail++;
            $display("FAIL %s end: got %h expected %h", name, obs(), idle_exp(1'b1));
        end
    endtask

    task automatic test_reset();
        logic [7:0] acc;
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (obs() !== idle_exp(1'b0)) begin
                n_fail++;
                $display("FAIL reset idle cycle %0d: got %h expected %h", i, obs(), idle_exp(1'b0));
            end
            step();
        end
        acc = 8'h00;
        for (int i = 0; i < 16; i++) acc = acc | dmem[i];
        n_checks++;
        if (acc !== 8'h00) begin
            n_fail++;
            $display("FAIL reset dmem: got %h expected 00", acc);
        end
    endtask

    task automatic test_basic_run();
        do_load(4'd0, 16'h0051);
        do_load(4'd1, 16'h0032);
        do_load(4'd2, 16'hB123);
        run_check("basic", 5'd3, -1, 1'b0);
        step();
        n_checks++;
        if (obs() !== idle_exp(1'b0)) begin
            n_fail++;
            $display("FAIL basic done-width: got %h expected %h", obs(), idle_exp(1'b0));
        end
        n_checks++;
        if (dmem[3] !== 8'd8) begin
            n_fail++;
            $display("FAIL basic dmem3: got %0d expected 8", dmem[3]);
        end
    endtask

    task automatic test_ignored_start();
        run_check("len0", 5'd0, -1, 1'b0);
        step();
        n_checks++;
        if (obs() !== idle_exp(1'b0)) begin
            n_fail++;
            $display("FAIL len0 later: got %h expected %h", obs(), idle_exp(1'b0));
        end
        prog_len = 5'd3; start = 1'b1;
        do_load(4'd5, 16'h1234);
        start = 1'b0;
        n_checks++;
        if (obs() !== idle_exp(1'b0)) begin
            n_fail++;
            $display("FAIL start-with-load: got %h expected %h", obs(), idle_exp(1'b0));
        end
        run_check("load-readback", 5'd6, -1, 1'b0);
        step();
    endtask

    task automatic test_clamp();
        for (int i = 0; i < 16; i++) do_load(i[3:0], 16'hA000 + 16'(i * 17));
        run_check("clamp", 5'd20, -1, 1'b0);
        step();
    endtask

    task automatic test_abort();
        run_check("abort", 5'd8, 2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (obs() !== idle_exp(1'b0)) begin
                n_fail++;
                $display("FAIL abort after %0d: got %h expected %h", i, obs(), idle_exp(1'b0));
            end
        end
    endtask

    task automatic test_back_to_back();
        run_check("b2b first", 5'd4, -1, 1'b0);
        run_check("b2b second", 5'd2, -1, 1'b0);
        run_check("b2b third", 5'd1, -1, 1'b0);
        step();
    endtask

    task automatic test_reset_mid_run();
        prog_len = 5'd8; start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) model_buf[i] = IDLE_W;
        n_checks++;
        if (obs() !== idle_exp(1'b0)) begin
            n_fail++;
            $display("FAIL reset mid-run: got %h expected %h", obs(), idle_exp(1'b0));
        end
        step();
        run_check("post-reset buffer", 5'd4, -1, 1'b0);
        step();
    endtask

    task automatic test_random();
        for (int r = 0; r < 25; r++) begin
            int n_loads;
            int l;
            logic [4:0] len;
            n_loads = $urandom_range(0, 4);
            for (int k = 0; k < n_loads; k++) do_load(4'($urandom), 16'($urandom));
            len = 5'($urandom);
            l = (len > 5'd16) ? 16 : int'(len);
            if ((l > 0) && ($urandom_range(0, 2) == 0))
                run_check("random", len, int'($urandom_range(0, l - 1)), 1'b1);
            else
                run_check("random", len, -1, 1'b1);
            if ($urandom_range(0, 1) == 1) step();
        end
        step();
    endtask

    initial begin
        rst = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
        prog_len = '0; start = 1'b0; abort = 1'b0;
        test_reset();
        test_basic_run();
        test_ignored_start();
        test_clamp();
        test_abort();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
